// File: rtl/snoop_fifo_wr_arbiter_if.sv
// ============================================================================
// Module   : snoop_fifo_wr_arbiter_if
// Brief    : Requester and FIFO write/snoop signal bundle for the write arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface snoop_fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 164
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               req_dup;
  logic [DW-1:0]      fifo_wdata;
  logic               fifo_wvalid;
  logic               fifo_wready;
  logic [DW-1:0]      fifo_sdata;
  logic               fifo_svalid;
  logic               fifo_smatch;

  // master: the arbiter itself
  modport master (
    input  req_valid, req_data, fifo_wready, fifo_smatch,
    output req_ready, req_dup, fifo_wdata, fifo_wvalid, fifo_sdata, fifo_svalid
  );

  // slave: requesters plus FIFO as seen from outside the arbiter
  modport slave (
    output req_valid, req_data, fifo_wready, fifo_smatch,
    input  req_ready, req_dup, fifo_wdata, fifo_wvalid, fifo_sdata, fifo_svalid
  );
endinterface

`default_nettype wire

// File: rtl/snoop_fifo_wr_arbiter.sv
// ============================================================================
// Module   : snoop_fifo_wr_arbiter
// Brief    : Round-robin write-port arbiter for the snoopable FIFO. Optional
//            duplicate drop (snoop before write) when SNOOP_ARB_DEDUP_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snoop_fifo_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 164,
  parameter int CW   = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rstn,
  snoop_fifo_wr_arbiter_if.master   bus,
  output logic [CW-1:0]             drop_count
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [GW:0] c_NREQ = (GW+1)'(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNOOP = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_g;
  logic [GW-1:0]   r_ptr;
  logic [DW-1:0]   r_wd;

  logic [DW-1:0]   w_words [NREQ];
  logic            w_found;
  logic [GW-1:0]   w_pick;
  logic [GW:0]     w_scan;
  logic [GW:0]     w_ptr_sum;
  logic [GW-1:0]   w_ptr_nxt;
  logic            w_grant;
  logic [NREQ-1:0] w_onehot;
  logic [NREQ-1:0] w_ready;
  logic            w_wvalid;
  logic [DW-1:0]   w_wdata;
`ifdef SNOOP_ARB_DEDUP_EN
  logic            w_svalid;
  logic [DW-1:0]   w_sdata;
  logic            w_dup;
  logic            w_drop;
  logic [CW-1:0]   r_drop_count;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_words[i] = bus.req_data[i*DW +: DW];
  end

  // Scan from the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_scan  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, r_ptr} + (GW+1)'(k);
      if (w_scan >= c_NREQ) begin
        w_scan = w_scan - c_NREQ;
      end
      if (!w_found && bus.req_valid[w_scan[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_scan[GW-1:0];
      end
    end
  end

  always_comb begin
    w_ptr_sum = {1'b0, w_pick} + (GW+1)'(1);
    if (w_ptr_sum >= c_NREQ) begin
      w_ptr_sum = '0;
    end
    w_ptr_nxt = w_ptr_sum[GW-1:0];
  end

  assign w_onehot = NREQ'(1) << r_g;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_ready     = '0;
    w_wvalid    = 1'b0;
    w_wdata     = '0;
`ifdef SNOOP_ARB_DEDUP_EN
    w_svalid    = 1'b0;
    w_sdata     = '0;
    w_dup       = 1'b0;
    w_drop      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant = 1'b1;
`ifdef SNOOP_ARB_DEDUP_EN
          w_state_nxt = ST_SNOOP;
`else
          w_state_nxt = ST_WRITE;
`endif
        end
      end
`ifdef SNOOP_ARB_DEDUP_EN
      ST_SNOOP: begin
        w_svalid = 1'b1;
        w_sdata  = r_wd;
        if (bus.fifo_smatch) begin
          w_ready     = w_onehot;
          w_dup       = 1'b1;
          w_drop      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
`endif
      ST_WRITE: begin
        // Full FIFO simply holds here; the word is never abandoned.
        w_wvalid = 1'b1;
        w_wdata  = r_wd;
        if (bus.fifo_wready) begin
          w_ready     = w_onehot;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state <= ST_IDLE;
      r_g     <= '0;
      r_ptr   <= '0;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_g   <= w_pick;
        r_wd  <= w_words[w_pick];
        r_ptr <= w_ptr_nxt;
      end
    end
  end

`ifdef SNOOP_ARB_DEDUP_EN
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != {CW{1'b1}})) begin
      r_drop_count <= r_drop_count + 1'b1;
    end
  end

  assign drop_count      = r_drop_count;
  assign bus.fifo_svalid = w_svalid;
  assign bus.fifo_sdata  = w_sdata;
  assign bus.req_dup     = w_dup;
`else
  logic w_unused_smatch;
  assign w_unused_smatch = bus.fifo_smatch;

  assign drop_count      = '0;
  assign bus.fifo_svalid = 1'b0;
  assign bus.fifo_sdata  = '0;
  assign bus.req_dup     = 1'b0;
`endif

  assign bus.req_ready   = w_ready;
  assign bus.fifo_wvalid = w_wvalid;
  assign bus.fifo_wdata  = w_wdata;

endmodule

`default_nettype wire

// File: tb/tb_snoop_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_snoop_fifo_wr_arbiter
// Brief    : Self-checking bench for snoop_fifo_wr_arbiter with a transaction
//            level reference model; honours SNOOP_ARB_DEDUP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snoop_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 164;
  localparam int CW   = 8;
`ifdef SNOOP_ARB_DEDUP_EN
  localparam int LAT  = 2;
`else
  localparam int LAT  = 1;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [CW-1:0] drop_count;

  snoop_fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  snoop_fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int req_prob = 0;

  // Reference model: one word in flight, optionally still awaiting its snoop.
  bit              m_busy;
  bit              m_snooped;
  int              m_g;
  int              m_ptr;
  logic [DW-1:0]   m_word;
  int              m_drops;
  logic [NREQ-1:0] m_ack;

  int log_idx[$];
  int log_cyc[$];
  int log_dup[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic model_reset();
    m_busy    = 1'b0;
    m_snooped = 1'b0;
    m_g       = 0;
    m_ptr     = 0;
    m_word    = '0;
    m_drops   = 0;
    m_ack     = '0;
  endtask

  task automatic clear_log();
    log_idx.delete();
    log_cyc.delete();
    log_dup.delete();
  endtask

  // Called at posedge+1 with inputs applied; checks, advances model, returns at next posedge+1.
  task automatic cycle();
    logic [NREQ-1:0] e_ready;
    logic            e_dup;
    logic            e_wv;
    logic            e_sv;
    logic [DW-1:0]   e_wd;
    logic [DW-1:0]   e_sd;
    bit              found;
    #1;
    e_ready = '0; e_dup = 1'b0; e_wv = 1'b0; e_sv = 1'b0; e_wd = '0; e_sd = '0;
    if (m_busy && !m_snooped) begin
      e_sv = 1'b1;
      e_sd = m_word;
      if (bus.fifo_smatch) begin
        e_ready[m_g] = 1'b1;
        e_dup        = 1'b1;
      end
    end else if (m_busy) begin
      e_wv = 1'b1;
      e_wd = m_word;
      if (bus.fifo_wready) e_ready[m_g] = 1'b1;
    end
    check("req_ready",   bus.req_ready,   e_ready);
    check("req_dup",     bus.req_dup,     e_dup);
    check("fifo_wvalid", bus.fifo_wvalid, e_wv);
    check("fifo_wdata",  bus.fifo_wdata,  e_wd);
    check("fifo_svalid", bus.fifo_svalid, e_sv);
    check("fifo_sdata",  bus.fifo_sdata,  e_sd);
    check("drop_count",  drop_count,      m_drops);
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i] === 1'b1) begin
        log_idx.push_back(i);
        log_cyc.push_back(cyc);
        log_dup.push_back(int'(bus.req_dup));
      end
    end
    if (rstn) begin
      model_reset();
    end else begin
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (!found && bus.req_valid[idx]) begin
            found     = 1'b1;
            m_busy    = 1'b1;
            m_g       = idx;
            m_word    = bus.req_data[idx*DW +: DW];
            m_ptr     = (idx + 1) % NREQ;
`ifdef SNOOP_ARB_DEDUP_EN
            m_snooped = 1'b0;
`else
            m_snooped = 1'b1;
`endif
          end
        end
      end else if (!m_snooped) begin
        if (bus.fifo_smatch) begin
          m_busy  = 1'b0;
          m_drops = (m_drops < (1 << CW) - 1) ? m_drops + 1 : m_drops;
        end else begin
          m_snooped = 1'b1;
        end
      end else if (bus.fifo_wready) begin
        m_busy = 1'b0;
      end
      m_ack = e_ready;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Requesters drop valid after their ack and may raise a fresh request.
  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (m_ack[i]) bus.req_valid[i] = 1'b0;
      if (!bus.req_valid[i] && ($urandom_range(99) < req_prob)) begin
        bus.req_valid[i]          = 1'b1;
        bus.req_data[i*DW +: DW]  = rand_word();
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      drive_reqs();
      cycle();
    end
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    run(1);
    rstn = 1'b0;
  endtask

  initial begin
    int start;
    int fair_exp[5];
    fair_exp = '{0, 1, 2, 3, 0};

    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.fifo_wready = 1'b1;
    bus.fifo_smatch = 1'b0;
    rstn            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    run(1);
    rstn = 1'b0;

    // Single request, checks latency and payload
    clear_log();
    bus.req_valid                  = 4'b0001;
    bus.req_data[DW-1:0]           = DW'(8'hA5);
    start = cyc;
    run(5);
    check("single_count", log_idx.size(), 1);
    if (log_idx.size() > 0) begin
      check("single_idx", log_idx[0], 0);
      check("single_lat", log_cyc[0] - start, LAT);
      check("single_dup", log_dup[0], 0);
    end

    // Fairness with all requesters continuously re-asserting
    do_reset();
    clear_log();
    bus.req_valid = '0;
    req_prob = 100;
    start = cyc;
    run(6 * (LAT + 1));
    req_prob = 0;
    run(20);
    check("fair_count_min", log_idx.size() >= 5, 1);
    for (int k = 0; k < 5; k++) begin
      if (k < log_idx.size()) begin
        check("fair_idx", log_idx[k], fair_exp[k]);
        if (k > 0) check("fair_gap", log_cyc[k] - log_cyc[k-1], LAT + 1);
      end
    end

    // Duplicate handling
    clear_log();
    bus.fifo_smatch = 1'b1;
    bus.req_valid   = 4'b0100;
    bus.req_data[2*DW +: DW] = rand_word();
    start = cyc;
    run(4);
    check("dup_count", log_idx.size(), 1);
    if (log_idx.size() > 0) begin
      check("dup_idx", log_idx[0], 2);
`ifdef SNOOP_ARB_DEDUP_EN
      check("dup_lat", log_cyc[0] - start, 1);
      check("dup_flag", log_dup[0], 1);
`else
      check("nodedup_lat", log_cyc[0] - start, 1);
      check("nodedup_flag", log_dup[0], 0);
`endif
    end
`ifdef SNOOP_ARB_DEDUP_EN
    check("drop_one", drop_count, 1);
`else
    check("drop_zero", drop_count, 0);
`endif
    req_prob = 100;
    run(620);
    req_prob = 0;
    run(20);
`ifdef SNOOP_ARB_DEDUP_EN
    check("drop_sat", drop_count, 255);
`else
    check("drop_stay_zero", drop_count, 0);
`endif
    bus.fifo_smatch = 1'b0;

    // Full FIFO stall
    clear_log();
    bus.fifo_wready = 1'b0;
    bus.req_valid   = 4'b0001;
    bus.req_data[DW-1:0] = rand_word();
    start = cyc;
    run(LAT + 5);
    check("full_noack", log_idx.size(), 0);
    bus.fifo_wready = 1'b1;
    run(3);
    check("full_ack_count", log_idx.size(), 1);
    if (log_idx.size() > 0) check("full_ack_cyc", log_cyc[0] - start, LAT + 5);

    // Reset while stalled in WRITE; requester 2 keeps asserting
    bus.fifo_wready = 1'b0;
    bus.req_valid   = 4'b0100;
    bus.req_data[2*DW +: DW] = rand_word();
    run(LAT + 2);
    rstn = 1'b1;
    run(1);
    rstn = 1'b0;
    bus.fifo_wready = 1'b1;
    clear_log();
    start = cyc;
    run(LAT + 3);
    check("rst_regrant_count", log_idx.size(), 1);
    if (log_idx.size() > 0) begin
      check("rst_regrant_idx", log_idx[0], 2);
      check("rst_regrant_lat", log_cyc[0] - start, LAT);
    end

    // Randomized traffic with back-pressure, matches and occasional reset
    req_prob = 30;
    for (int c = 0; c < 3000; c++) begin
      bus.fifo_wready = ($urandom_range(99) < 70);
      bus.fifo_smatch = ($urandom_range(99) < 30);
      rstn            = ($urandom_range(999) < 5);
      drive_reqs();
      cycle();
    end
    rstn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/snoop_fifo_wr_arbiter.md
# snoop_fifo_wr_arbiter

Round-robin write-port arbiter and sequencer for the snoopable FIFO. Up to NREQ requesters share the single FIFO write port. With deduplication compiled in, each granted word is first snooped against current FIFO contents; a word already queued is acknowledged and dropped instead of written. The block sits directly in front of the FIFO's wdata/wvalid/wready and sdata/svalid/smatch ports and is the FIFO's only writer.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 164, data word width, equal to the FIFO width
- CW, 8, drop counter width
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-high (asserted = 1)
- req_valid  in  NREQ  per-requester request; held high with data stable until that requester's req_ready pulse
- req_data  in  NREQ*DW  requester i word at [i*DW +: DW]
- req_ready  out  NREQ  one-hot, one-cycle acknowledge; word consumed (written or dropped)
- req_dup  out  1  high with req_ready when the word was dropped as duplicate
- fifo_wdata  out  DW  write data to FIFO
- fifo_wvalid  out  1  write request to FIFO
- fifo_wready  in  1  FIFO not full
- fifo_sdata  out  DW  snoop compare word
- fifo_svalid  out  1  snoop strobe
- fifo_smatch  in  1  combinational match result, valid in same cycle as fifo_svalid
- drop_count  out  CW  saturating count of dropped duplicates

## Operation
- State machine: IDLE, SNOOP, WRITE. Registers: state, grant index g, RR pointer ptr, latched word wd, drop_count.
- IDLE: if any req_valid, pick the first set bit scanning ptr, ptr+1, ... modulo NREQ. Latch g and wd = req_data[g]. Go to SNOOP (DEDUP) or WRITE (no DEDUP). Set ptr = (g+1) mod NREQ. If no req_valid, stay in IDLE.
- SNOOP: fifo_svalid=1, fifo_sdata=wd for exactly one cycle.
  - fifo_smatch=1: req_ready[g]=1, req_dup=1, drop_count +1 (saturates at 2^CW-1), go to IDLE.
  - Otherwise: go to WRITE.
- WRITE: fifo_wvalid=1, fifo_wdata=wd.
  - Each cycle with fifo_wready=1: handshake; req_ready[g]=1, req_dup=0, go to IDLE.
  - fifo_wready=0 (full): hold WRITE with wvalid and wdata stable. No re-arbitration and no timeout.
- Outputs are registered-state decodes. fifo_wdata and fifo_sdata read 0 outside WRITE and SNOOP respectively.
- Snoop covers FIFO contents at the SNOOP cycle only. A FIFO pop between SNOOP and WRITE does not re-trigger a snoop.

## Timing
- Reset values: state IDLE, ptr 0, g 0, wd 0, drop_count 0. All outputs 0.
- Reset asserted in any state takes effect at the next edge. Any in-flight word is discarded without ack; a requester still asserting valid is re-arbitrated after reset.
- Write latency with DEDUP and FIFO not full: req_valid seen in IDLE at cycle 0, SNOOP cycle 1, WRITE plus req_ready at cycle 2. Without DEDUP: req_ready at cycle 1.
- Drop latency: req_ready with req_dup at cycle 1.
- Throughput: one word per 3 cycles (DEDUP) or 2 cycles (no DEDUP). There is always one IDLE cycle between grants.
- A requester whose valid drops before its ack is protocol violation. The latched word is still processed.
- Simultaneous requests: exactly one grant per IDLE cycle. No requester waits more than NREQ-1 grants.

## Configuration
- Macro SNOOP_ARB_DEDUP_EN.
- Defined: SNOOP state present; duplicates dropped and counted.
- Undefined: IDLE goes directly to WRITE. fifo_svalid, fifo_sdata, req_dup and drop_count are tied to 0, and fifo_smatch is ignored.

## Test plan
- Single req: req_valid=4'b0001, data 0xA5, smatch=0, wready=1 -> fifo_wvalid at cycle 2 with wdata 0xA5; req_ready=4'b0001 at cycle 2, req_dup=0.
- Fairness: req_valid=4'b1111 held, each requester re-asserts after ack -> grants in order 0,1,2,3,0, one every 3 cycles.
- Duplicate: smatch=1 during SNOOP -> req_ready pulse with req_dup=1, no fifo_wvalid, drop_count 0->1. Force 300 drops with CW=8 -> drop_count stops at 255.
- Full FIFO: wready=0 for 5 cycles in WRITE -> wvalid and wdata held stable, no req_ready. wready=1 -> ack same cycle, next IDLE.
- Reset mid-WRITE: rstn=1 while wready=0 -> next cycle all outputs 0, ptr 0. Requester 2 still valid -> regranted after reset deasserts.
- Macro undefined: req_valid=4'b0100 -> req_ready=4'b0100 at cycle 1; svalid never asserted; drop_count stays 0 even with smatch=1.
